// File: rtl/aes_spi_host.sv
// ---------------------------------------------------------------------------
// aes_spi_host
//
// SPI host that drives the AES SPI subordinate. A parallel encryption
// request (key-size mode, MSB-aligned key, 128-bit plaintext) is serialised
// as up to three SPI mode-0 frames, each in its own cs-low window:
//   K : 258 bits {mode, key}            (only when a key must be sent)
//   D : 258 bits {mode, plaintext, 0s}
//   R : 128 bits, sdi=0, ciphertext sampled from sdo MSB first
// The ciphertext is then presented on result with a one-cycle result_valid.
//
// Handshake: a request is taken when start=1 in a cycle where busy=0.
// busy rises the following cycle and stays high up to and including the
// result_valid cycle, so start in that cycle is ignored. A request with
// mode=11 is not taken; it only produces a one-cycle err pulse.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   start              request strobe
//   new_key            1 = send key frame (forced when no key sent yet)
//   mode[1:0]          00=AES-128, 01=AES-192, 10=AES-256, 11 illegal
//   key[255:0]         key, MSB-aligned
//   plaintext[127:0]   message block
//   busy               transaction in progress
//   result[127:0]      ciphertext, held until the next result_valid
//   result_valid       one-cycle pulse when result updates
//   err                one-cycle pulse for a rejected mode=11 request
//   cs, sclk, sdi      SPI host outputs (cs active-low, sclk idles low)
//   sdo                SPI data from the subordinate
//   dbg_state_o[2:0]   current FSM state, for observation only
// ---------------------------------------------------------------------------
module aes_spi_host #(
    parameter int CLK_DIV  = 2,   // clk cycles per sclk half-period (>=1)
    parameter int CS_SETUP = 2,   // cs-to-shift and shift-to-cs clk cycles (>=1)
    parameter int CS_GAP   = 4    // clk cycles cs stays high between frames (>=1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         new_key,
    input  logic [1:0]   mode,
    input  logic [255:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         err,
    output logic         cs,
    output logic         sclk,
    output logic         sdi,
    input  logic         sdo,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_SHIFT  = 3'd3,
        S_HOLD   = 3'd4,
        S_GAP    = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        FR_K = 2'd0,
        FR_D = 2'd1,
        FR_R = 2'd2
    } frame_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

    state_t         state_q, state_d;
    frame_t         frame_q;
    logic [15:0]    timer_q;
    logic [8:0]     bit_cnt_q;
    logic           sclk_q;
    logic [257:0]   sr_q;
    logic [127:0]   rx_q;
    logic [127:0]   result_q;
    logic           err_q;
    logic           key_sent_q;
    logic           need_key_q;
    logic [1:0]     mode_q;
    logic [255:0]   key_q;
    logic [127:0]   pt_q;

    logic           idle;
    logic           accept;
    logic           reject;
    logic           half_done;
    logic           rise_edge;
    logic           fall_edge;
    logic [8:0]     frame_last;
    logic           last_bit;
    logic           gap_done;

    assign idle       = (state_q == S_IDLE);
    assign accept     = idle && start && (mode != 2'b11);
    assign reject     = idle && start && (mode == 2'b11);
    assign half_done  = (state_q == S_SHIFT) && (timer_q == DIV_LAST);
    // sclk_q is the level before the toggle, so 0 means this edge rises.
    assign rise_edge  = half_done && !sclk_q;
    assign fall_edge  = half_done && sclk_q;
    assign frame_last = (frame_q == FR_R) ? 9'd127 : 9'd257;
    assign last_bit   = (bit_cnt_q == frame_last);
    assign gap_done   = (state_q == S_GAP) && (timer_q == GAP_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOAD;
            S_LOAD:   state_d = S_SETUP;
            S_SETUP:  if (timer_q == SETUP_LAST) state_d = S_SHIFT;
            S_SHIFT:  if (fall_edge && last_bit) state_d = S_HOLD;
            S_HOLD:   if (timer_q == SETUP_LAST) state_d = S_GAP;
            S_GAP:    if (gap_done) state_d = (frame_q == FR_R) ? S_FINISH : S_SETUP;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: timers, shift registers, captured request, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= FR_K;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            sr_q       <= '0;
            rx_q       <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            key_sent_q <= 1'b0;
            need_key_q <= 1'b0;
            mode_q     <= '0;
            key_q      <= '0;
            pt_q       <= '0;
        end else begin
            err_q <= reject;

            // One timer serves every wait state; it restarts on each state
            // change and on each sclk half-period inside SHIFT.
            if (state_d != state_q || half_done) begin
                timer_q <= '0;
            end else if (!idle) begin
                timer_q <= timer_q + 16'd1;
            end

            if (accept) begin
                mode_q     <= mode;
                key_q      <= key;
                pt_q       <= plaintext;
                need_key_q <= new_key | ~key_sent_q;
            end

            if (state_q == S_LOAD) begin
                bit_cnt_q <= '0;
                if (need_key_q) begin
                    frame_q <= FR_K;
                    sr_q    <= {mode_q, key_q};
                end else begin
                    frame_q <= FR_D;
                    sr_q    <= {mode_q, pt_q, 128'b0};
                end
            end

            // Next frame is loaded while cs is still high, so sdi is valid
            // for the whole SETUP window.
            if (gap_done && frame_q != FR_R) begin
                bit_cnt_q <= '0;
                if (frame_q == FR_K) begin
                    frame_q <= FR_D;
                    sr_q    <= {mode_q, pt_q, 128'b0};
                end else begin
                    frame_q <= FR_R;
                    sr_q    <= '0;
                end
            end

            if (gap_done && frame_q == FR_R) begin
                result_q <= rx_q;
            end

            if (half_done) begin
                sclk_q <= ~sclk_q;
            end

            // Mode 0: sdi advances after sclk falls.
            if (fall_edge) begin
                sr_q      <= {sr_q[256:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 9'd1;
                if (last_bit && frame_q == FR_K) begin
                    key_sent_q <= 1'b1;
                end
            end

            if (rise_edge && frame_q == FR_R) begin
                rx_q <= {rx_q[126:0], sdo};
            end
        end
    end

    // Outputs decoded from state
    always_comb begin
        cs           = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
        sdi          = 1'b0;
        if (((state_q == S_SETUP) || (state_q == S_SHIFT)) && frame_q != FR_R) begin
            sdi = sr_q[257];
        end
        busy         = !idle;
        result_valid = (state_q == S_FINISH);
        err          = err_q;
        result       = result_q;
        sclk         = sclk_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_aes_spi_host.sv
module tb_aes_spi_host;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 4;
    localparam int LIMIT    = 30000;

    // ---------------- clock / reset / inputs ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         new_key = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [255:0] key = '0;
    logic [127:0] plaintext = '0;

    logic         busy, result_valid, err, cs, sclk, sdi, sdo;
    logic [127:0] result;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    aes_spi_host #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .new_key(new_key), .mode(mode),
        .key(key), .plaintext(plaintext), .busy(busy), .result(result),
        .result_valid(result_valid), .err(err), .cs(cs), .sclk(sclk),
        .sdi(sdi), .sdo(sdo), .dbg_state_o(dbg_state)
    );

    // ---------------- subordinate model / bus monitor ----------------
    logic         bits_q[$];
    logic [257:0] frm_q[$];
    int           len_q[$];
    int           start_bit = 0, fall_total = 0, start_fall = 0;
    int           cs_falls = 0, frames_done = 0;
    int           idle_r = 0, idle_f = 0, rv_cnt = 0, cyc_ctr = 0;
    logic [127:0] resp = '0;
    int           sdo_idx;

    assign sdo_idx = fall_total - start_fall;
    assign sdo = (cs === 1'b0 && sdo_idx >= 0 && sdo_idx < 128) ? resp[7'(127 - sdo_idx)] : 1'b0;

    always @(negedge cs) begin
        cs_falls++;
        start_bit  = bits_q.size();
        start_fall = fall_total;
    end

    always @(posedge sclk) begin
        if (cs === 1'b0) bits_q.push_back(sdi);
        else idle_r++;
    end

    always @(negedge sclk) begin
        fall_total++;
        if (cs === 1'b1) idle_f++;
    end

    always @(posedge cs) begin : mon_cs
        logic [257:0] v;
        v = '0;
        if (cs_falls > frames_done) begin
            for (int i = start_bit; i < bits_q.size(); i++) v = {v[256:0], bits_q[i]};
            frm_q.push_back(v);
            len_q.push_back(bits_q.size() - start_bit);
            frames_done++;
        end
    end

    always @(posedge clk) begin
        cyc_ctr++;
        if (result_valid === 1'b1) rv_cnt++;
    end

    // ---------------- extra instances: CLK_DIV = 1 and 5 ----------------
    logic [1:0]   start_div = 2'b00;
    logic [1:0]   rv_div, cs_div, sclk_div, busy_div;
    logic [127:0] res_div [2];
    int           pmin_div [2], pmax_div [2], idle_div [2];

    for (genvar g = 0; g < 2; g++) begin : g_div
        localparam int DV = (g == 0) ? 1 : 5;
        logic         b_w, rv_w, e_w, cs_w, sclk_w, sdi_w;
        logic [127:0] res_w;
        logic [2:0]   st_w;
        int fcnt = 0, seen = 0, prev = 0, pmin = 1 << 30, pmax = 0, idle_p = 0, idle_n = 0;

        aes_spi_host #(.CLK_DIV(DV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) u_dut (
            .clk(clk), .rst(rst), .start(start_div[g]), .new_key(new_key), .mode(mode),
            .key(key), .plaintext(plaintext), .busy(b_w), .result(res_w),
            .result_valid(rv_w), .err(e_w), .cs(cs_w), .sclk(sclk_w),
            .sdi(sdi_w), .sdo(1'b1), .dbg_state_o(st_w)
        );

        always @(negedge cs_w) fcnt++;
        always @(posedge sclk_w) begin
            if (cs_w === 1'b1) begin
                idle_p++;
            end else if (fcnt != seen) begin
                seen = fcnt;
                prev = cyc_ctr;
            end else begin
                if (cyc_ctr - prev < pmin) pmin = cyc_ctr - prev;
                if (cyc_ctr - prev > pmax) pmax = cyc_ctr - prev;
                prev = cyc_ctr;
            end
        end
        always @(negedge sclk_w) if (cs_w === 1'b1) idle_n++;

        assign rv_div[g]   = rv_w;
        assign cs_div[g]   = cs_w;
        assign sclk_div[g] = sclk_w;
        assign busy_div[g] = b_w;
        assign res_div[g]  = res_w;
        assign pmin_div[g] = pmin;
        assign pmax_div[g] = pmax;
        assign idle_div[g] = idle_p + idle_n;
    end

    // ---------------- scoring ----------------
    int n_vec = 0;
    int n_bad = 0;
    bit mk_sent = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [257:0] obs, input logic [257:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
        end
    endtask

    // Reference cost of one frame in clk cycles.
    function automatic int fcost(input int nbits, input int dv);
        return nbits * 2 * dv + 2 * CS_SETUP + CS_GAP;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [255:0] mask_key(input logic [255:0] k, input logic [1:0] m);
        logic [255:0] r;
        r = k;
        if (m == 2'b00) r[127:0] = '0;
        else if (m == 2'b01) r[63:0] = '0;
        return r;
    endfunction

    task automatic run_txn(input logic nk, input logic [1:0] m, input logic [255:0] k,
                           input logic [127:0] p, input logic [127:0] r, input bit hammer);
        int base_f, base_rv, base_idle, cyc, exp_lat;
        bit send_k;
        logic [257:0] exp_fr[$];
        int exp_len[$];
        send_k = nk || !mk_sent;
        if (send_k) begin
            exp_fr.push_back({m, k});
            exp_len.push_back(258);
        end
        exp_fr.push_back({m, p, 128'b0});
        exp_len.push_back(258);
        exp_fr.push_back('0);
        exp_len.push_back(128);
        exp_lat = 2;
        foreach (exp_len[i]) exp_lat += fcost(exp_len[i], CLK_DIV);

        @(negedge clk);
        resp = r;
        base_f = frm_q.size();
        base_rv = rv_cnt;
        base_idle = idle_r + idle_f;
        new_key = nk; mode = m; key = k; plaintext = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk1("busy_rise", busy, 1'b1);
        while (result_valid !== 1'b1 && cyc < LIMIT) begin
            if (hammer) start = (cyc % 5 == 0);
            @(negedge clk);
            cyc++;
        end
        chk1("result_valid_seen", result_valid, 1'b1);
        if (hammer) start = 1'b1;   // lands in the result_valid cycle
        chk_lat("latency", cyc, exp_lat);
        chkv("result", 258'(result), 258'(r));
        chki("frame_count", frm_q.size() - base_f, exp_fr.size());
        foreach (exp_fr[i]) begin
            if (base_f + i < frm_q.size()) begin
                chki("frame_len", len_q[base_f + i], exp_len[i]);
                chkv("frame_bits", frm_q[base_f + i], exp_fr[i]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chki("rv_pulses", rv_cnt - base_rv, 1);
        chk1("busy_after", busy, 1'b0);
        chk1("rv_after", result_valid, 1'b0);
        chk1("cs_after", cs, 1'b1);
        chk1("sclk_after", sclk, 1'b0);
        chkv("result_held", 258'(result), 258'(r));
        chki("idle_sclk_edges", idle_r + idle_f - base_idle, 0);
        mk_sent = mk_sent | send_k;
        if (hammer) begin
            repeat (10) @(negedge clk);
            chk1("hammer_busy", busy, 1'b0);
            chki("hammer_frames", frm_q.size() - base_f, exp_fr.size());
            chki("hammer_rv", rv_cnt - base_rv, 1);
        end
    endtask

    task automatic run_div(input int idx);
        int dv, cyc, exp_lat, base_idle;
        dv = (idx == 0) ? 1 : 5;
        exp_lat = 2 + 2 * fcost(258, dv) + fcost(128, dv);
        @(negedge clk);
        base_idle = idle_div[idx];
        new_key = 1'b1; mode = 2'b00; key = mask_key(rand256(), 2'b00);
        start_div[idx] = 1'b1;
        @(negedge clk);
        start_div[idx] = 1'b0;
        cyc = 1;
        chk1("div_busy", busy_div[idx], 1'b1);
        while (rv_div[idx] !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk1("div_rv_seen", rv_div[idx], 1'b1);
        chk_lat("div_latency", cyc, exp_lat);
        chkv("div_result", 258'(res_div[idx]), 258'({128{1'b1}}));
        chki("div_period_min", pmin_div[idx], 2 * dv);
        chki("div_period_max", pmax_div[idx], 2 * dv);
        @(negedge clk);
        chki("div_idle_edges", idle_div[idx] - base_idle, 0);
        chk1("div_sclk_idle", sclk_div[idx], 1'b0);
        chk1("div_cs_idle", cs_div[idx], 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main_seq
        int base_f, base_rv, base_cs, cyc;
        logic [1:0] m;
        logic [255:0] k0;

        k0 = {128'h000102030405060708090A0B0C0D0E0F, 128'h0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_cs", cs, 1'b1);
        chk1("rst_sclk", sclk, 1'b0);
        chk1("rst_sdi", sdi, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rv", result_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkv("rst_result", 258'(result), 258'(0));
        rst = 1'b0;
        @(negedge clk);

        // Known-answer transaction, fresh key.
        run_txn(1'b1, 2'b00, k0, 128'h00112233445566778899AABBCCDDEEFF,
                128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b0);
        // Key reuse: only D and R.
        run_txn(1'b0, 2'b00, k0, 128'(rand256()), 128'(rand256()), 1'b0);

        // Randomised requests.
        for (int t = 0; t < 3; t++) begin
            m = 2'($urandom_range(0, 2));
            run_txn(1'($urandom_range(0, 1)), m, mask_key(rand256(), m),
                    128'(rand256()), 128'(rand256()), 1'b0);
        end

        // Illegal mode.
        @(negedge clk);
        base_f = frm_q.size();
        mode = 2'b11; new_key = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("illegal_err", err, 1'b1);
        chk1("illegal_busy", busy, 1'b0);
        chk1("illegal_cs", cs, 1'b1);
        @(negedge clk);
        chk1("illegal_err_drop", err, 1'b0);
        chk1("illegal_busy2", busy, 1'b0);
        repeat (5) @(negedge clk);
        chki("illegal_frames", frm_q.size() - base_f, 0);

        // start hammered during busy and in the result_valid cycle.
        m = 2'($urandom_range(0, 2));
        run_txn(1'b0, m, mask_key(rand256(), m), 128'(rand256()), 128'(rand256()), 1'b1);

        // Reset in the middle of frame D.
        @(negedge clk);
        base_rv = rv_cnt;
        base_cs = cs_falls;
        new_key = 1'b0; mode = 2'b01; key = mask_key(rand256(), 2'b01);
        plaintext = 128'(rand256()); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(cs === 1'b0 && cs_falls > base_cs && bits_q.size() - start_bit >= 100) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk1("midrst_reached", (cyc < LIMIT), 1'b1);
        rst = 1'b1;
        #1;
        chk1("midrst_cs", cs, 1'b1);
        chk1("midrst_sclk", sclk, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_sdi", sdi, 1'b0);
        chkv("midrst_result", 258'(result), 258'(0));
        @(negedge clk);
        rst = 1'b0;
        mk_sent = 1'b0;
        @(negedge clk);
        chki("midrst_no_rv", rv_cnt - base_rv, 0);
        m = 2'($urandom_range(0, 2));
        run_txn(1'b0, m, mask_key(rand256(), m), 128'(rand256()), 128'(rand256()), 1'b0);

        // Other sclk dividers.
        run_div(0);
        run_div(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
